uart_autobaud_ctrl: RTL and testbench
=====================================

// Module: uart_autobaud_ctrl
// PURPOSE
//  Configures the UART 16x baud clock generator. It measures the first two bit times of a 0x55 sync
//  character on RX, then derives and drives baud_val[12:0] and baud_val_fraction[2:0].
//  Software can override the result via cfg_load. Sits between the APB register file and the baud clock generator.
// PARAMETERS
//  CNT_W            17     width of bit-time counter (clk cycles); saturation = timeout
//  DEFAULT_BAUD_VAL 13'd0  baud_val after reset / before first lock
//  MIN_CNT          32     shortest legal bit time (clk cycles); shorter = glitch error
// PORTS
//  clk               in   1   system clock
//  reset_n           in   1   async active-low reset
//  autobaud_en       in   1   1 = measurement enabled; 0 = abort to IDLE, outputs held
//  restart           in   1   pulse: drop lock, re-arm measurement
//  rx                in   1   raw serial input (asynchronous)
//  cfg_load          in   1   pulse: load cfg_baud_val/cfg_fraction directly
//  cfg_baud_val      in   13  manual baud value
//  cfg_fraction      in   3   manual fraction
//  baud_val          out  13  to clock generator
//  baud_val_fraction out  3   to clock generator
//  baud_upd          out  1   1-cycle pulse when baud_val/fraction change
//  locked            out  1   valid rate held
//  err               out  1   1-cycle pulse: timeout, glitch or mismatch
// BEHAVIOUR
//  Reset: baud_val=DEFAULT_BAUD_VAL, fraction=0, baud_upd=0, locked=0, err=0, state=IDLE, counters=0.
//  rx passes a 2-flop synchronizer, then an edge detector: 3 clk latency from pin to edge event.
//  FSM:
//   IDLE   : autobaud_en & !locked -> ARM.
//   ARM    : wait for rx high >=1 cycle, then falling edge -> LO, cnt=1.
//   LO     : cnt++ while rx low. On rising edge: n_lo=cnt, cnt=1, -> HI.
//   HI     : cnt++ while rx high. On falling edge: n_hi=cnt -> CHECK.
//   CHECK  : one cycle.
//            Pass if n_lo>=MIN_CNT and |n_lo-n_hi| <= n_lo>>3: update outputs from n_lo, baud_upd=1, locked=1 -> LOCKED.
//            Else err=1 -> ARM.
//   LOCKED : hold outputs; restart -> locked=0 -> ARM.
//  Timeout: cnt reaching all-ones in LO or HI -> err=1 -> ARM. The counter never wraps.
//  Arithmetic, N=n_lo, with macro set: baud_val = N[CNT_W-1:4]-1; fraction = N[3:1].
//   Clamp: N>>4 == 0 is impossible (N>=MIN_CNT). If N[CNT_W-1:4]-1 > 8191, saturate to 8191.
//  Priority, same cycle: reset > cfg_load > restart > !autobaud_en > FSM event.
//  cfg_load in any state: outputs <= cfg values, baud_upd=1, locked=1, state=LOCKED. Any measurement is aborted.
//  autobaud_en deasserted mid-measurement: -> IDLE, no err, outputs and locked unchanged.
//  baud_upd is asserted only when a new value is written, even if that value is unchanged.
// CONFIGURATION
//  UART_AUTOBAUD_FRCTN_EN defined:
//   fraction computed as above; cfg_fraction passed through.
//  UART_AUTOBAUD_FRCTN_EN undefined:
//   baud_val = ((N+8)>>4)-1, i.e. rounded to nearest.
//   baud_val_fraction tied 3'b000; cfg_fraction ignored.
// STRUCTURE
//  Shared package/include uart_autobaud_pkg: FSM state localparams
//   (IDLE, ARM, LO, HI, CHECK, LOCKED; 3-bit encoding), BAUD_W=13, FRAC_W=3.
//  Sub-module uart_rx_sync_edge: 2-flop synchronizer + registered rise/fall pulses.
//   Reused later by the receiver.
// TESTING
//  1) Macro on, 0x55 at N=434 clk/bit (50MHz, 115200) -> baud_val=26, fraction=1, baud_upd 1 pulse, locked=1.
//  2) Macro off, same stimulus -> baud_val=26, fraction=0.
//     N=440 -> baud_val=27 (rounding check).
//  3) Low pulse of 20 clk, then high 20 clk -> err pulse, locked=0, re-armed.
//     Next valid 0x55 at N=434 locks.
//  4) Low of 434 then high of 520 (mismatch >1/8) -> err, no update.
//     rx held low 2^17 cycles -> timeout err.
//  5) cfg_load (baud_val=100, fraction=5) in same cycle as restart during LO -> outputs 100/5, locked=1, state LOCKED.
//  6) reset_n asserted mid-HI -> all outputs to reset values immediately.
//     After release, full 0x55 re-measure succeeds.

Source files
------------

// File: rtl/uart_autobaud_pkg.sv
// Shared definitions for the UART auto-baud controller and its RX front end.
package uart_autobaud_pkg;

  localparam int unsigned BAUD_W   = 13;
  localparam int unsigned FRAC_W   = 3;
  localparam int unsigned BAUD_MAX = (1 << BAUD_W) - 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_LO     = 3'd2,
    ST_HI     = 3'd3,
    ST_CHECK  = 3'd4,
    ST_LOCKED = 3'd5
  } state_t;

endpackage

// File: rtl/uart_rx_sync_edge.sv
// Two-flop synchronizer for an asynchronous serial input plus registered edge pulses.
// Edge pulses appear 3 clk after the pin changes; level_o is aligned with them.
module uart_rx_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic rx_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, dly_q, rise_q, fall_q;

  // Line idles high, so the chain resets high to avoid a spurious edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      dly_q  <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
      dly_q  <= sync_q;
      rise_q <= sync_q & ~dly_q;
      fall_q <= ~sync_q & dly_q;
    end
  end

  assign level_o = dly_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/uart_autobaud_ctrl.sv
// Auto-baud controller: times the start bit and bit 0 of a 0x55 sync character and
// programs the 16x baud generator. Fractional divider output enabled by UART_AUTOBAUD_FRCTN_EN.
module uart_autobaud_ctrl
  import uart_autobaud_pkg::*;
#(
  parameter int unsigned       CNT_W            = 17,
  parameter logic [BAUD_W-1:0] DEFAULT_BAUD_VAL = 13'd0,
  parameter int unsigned       MIN_CNT          = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              autobaud_en,
  input  logic              restart,
  input  logic              rx,
  input  logic              cfg_load,
  input  logic [BAUD_W-1:0] cfg_baud_val,
  input  logic [FRAC_W-1:0] cfg_fraction,
  output logic [BAUD_W-1:0] baud_val,
  output logic [FRAC_W-1:0] baud_val_fraction,
  output logic              baud_upd,
  output logic              locked,
  output logic              err
);

  logic rx_level, rx_rise, rx_fall;

  uart_rx_sync_edge u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .rx_i    (rx),
    .level_o (rx_level),
    .rise_o  (rx_rise),
    .fall_o  (rx_fall)
  );

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q, n_lo_q, n_hi_q;
  logic              seen_high_q;
  logic [BAUD_W-1:0] baud_q;
  logic [FRAC_W-1:0] frac_q;
  logic              upd_q, locked_q, err_q;

  logic [CNT_W-1:0]  cnt_inc_d;
  logic [CNT_W-1:0]  diff;
  logic              meas_ok;
  logic [31:0]       coarse_w;
  logic [BAUD_W-1:0] lock_baud_d;
  logic [FRAC_W-1:0] lock_frac_d;
  logic [FRAC_W-1:0] cfg_frac;

  assign cnt_inc_d = cnt_q + CNT_W'(1);
  assign diff      = (n_lo_q >= n_hi_q) ? (n_lo_q - n_hi_q) : (n_hi_q - n_lo_q);
  assign meas_ok   = (n_lo_q >= CNT_W'(MIN_CNT)) && (diff <= (n_lo_q >> 3));

`ifdef UART_AUTOBAUD_FRCTN_EN
  logic [CNT_W-1:0] coarse;
  assign coarse      = (n_lo_q >> 4) - CNT_W'(1);
  assign lock_frac_d = n_lo_q[3:1];
  assign cfg_frac    = cfg_fraction;
`else
  // Extra bit keeps N+8 from wrapping before the divide-by-16.
  logic [CNT_W:0] coarse;
  logic           cfg_fraction_unused;
  assign coarse              = (({1'b0, n_lo_q} + (CNT_W+1)'(8)) >> 4) - (CNT_W+1)'(1);
  assign lock_frac_d         = '0;
  assign cfg_frac            = '0;
  assign cfg_fraction_unused = ^cfg_fraction;
`endif

  assign coarse_w    = 32'(coarse);
  assign lock_baud_d = (coarse_w > 32'(BAUD_MAX)) ? '1 : coarse_w[BAUD_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      n_lo_q      <= '0;
      n_hi_q      <= '0;
      seen_high_q <= 1'b0;
      baud_q      <= DEFAULT_BAUD_VAL;
      frac_q      <= '0;
      upd_q       <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      err_q <= 1'b0;
      if (cfg_load) begin
        baud_q   <= cfg_baud_val;
        frac_q   <= cfg_frac;
        upd_q    <= 1'b1;
        locked_q <= 1'b1;
        cnt_q    <= '0;
        state_q  <= ST_LOCKED;
      end else if (restart) begin
        locked_q    <= 1'b0;
        cnt_q       <= '0;
        seen_high_q <= 1'b0;
        state_q     <= ST_ARM;
      end else if (!autobaud_en) begin
        cnt_q   <= '0;
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (!locked_q) begin
              seen_high_q <= 1'b0;
              state_q     <= ST_ARM;
            end
          end
          // A falling edge only starts a measurement once the line was seen idle high.
          ST_ARM: begin
            if (rx_fall && seen_high_q) begin
              cnt_q   <= CNT_W'(1);
              state_q <= ST_LO;
            end else if (rx_level) begin
              seen_high_q <= 1'b1;
            end
          end
          ST_LO: begin
            if (rx_rise) begin
              n_lo_q  <= cnt_q;
              cnt_q   <= CNT_W'(1);
              state_q <= ST_HI;
            end else if (&cnt_q) begin
              err_q       <= 1'b1;
              seen_high_q <= 1'b0;
              state_q     <= ST_ARM;
            end else begin
              cnt_q <= cnt_inc_d;
            end
          end
          ST_HI: begin
            if (rx_fall) begin
              n_hi_q  <= cnt_q;
              state_q <= ST_CHECK;
            end else if (&cnt_q) begin
              err_q       <= 1'b1;
              seen_high_q <= 1'b0;
              state_q     <= ST_ARM;
            end else begin
              cnt_q <= cnt_inc_d;
            end
          end
          ST_CHECK: begin
            if (meas_ok) begin
              baud_q   <= lock_baud_d;
              frac_q   <= lock_frac_d;
              upd_q    <= 1'b1;
              locked_q <= 1'b1;
              state_q  <= ST_LOCKED;
            end else begin
              err_q       <= 1'b1;
              seen_high_q <= 1'b0;
              state_q     <= ST_ARM;
            end
          end
          ST_LOCKED: ;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign baud_val          = baud_q;
  assign baud_val_fraction = frac_q;
  assign baud_upd          = upd_q;
  assign locked            = locked_q;
  assign err               = err_q;

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Scoreboard bench for uart_autobaud_ctrl; honours UART_AUTOBAUD_FRCTN_EN like the RTL.
module tb_uart_autobaud_ctrl;

  localparam int CNT_W   = 12;
  localparam int MIN_CNT = 32;

  logic        clk = 1'b0;
  logic        reset_n, autobaud_en, restart, rx, cfg_load;
  logic [12:0] cfg_baud_val;
  logic [2:0]  cfg_fraction;
  logic [12:0] baud_val;
  logic [2:0]  baud_val_fraction;
  logic        baud_upd, locked, err;

  uart_autobaud_ctrl #(
    .CNT_W            (CNT_W),
    .DEFAULT_BAUD_VAL (13'd0),
    .MIN_CNT          (MIN_CNT)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .autobaud_en       (autobaud_en),
    .restart           (restart),
    .rx                (rx),
    .cfg_load          (cfg_load),
    .cfg_baud_val      (cfg_baud_val),
    .cfg_fraction      (cfg_fraction),
    .baud_val          (baud_val),
    .baud_val_fraction (baud_val_fraction),
    .baud_upd          (baud_upd),
    .locked            (locked),
    .err               (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_err;
    int baud;
    int frac;
    bit lck;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   hold_baud = 0;
  int   hold_frac = 0;
  bit   hold_locked = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model: bit-time rules in plain integer arithmetic.
  function automatic bit meas_pass(input int lo, input int hi);
    int d;
    d = (lo > hi) ? lo - hi : hi - lo;
    return (lo >= MIN_CNT) && (d <= lo / 8);
  endfunction

  function automatic int model_baud(input int n);
    int b;
`ifdef UART_AUTOBAUD_FRCTN_EN
    b = n / 16 - 1;
`else
    b = (n + 8) / 16 - 1;
`endif
    if (b > 8191) b = 8191;
    return b;
  endfunction

  function automatic int model_frac(input int n);
`ifdef UART_AUTOBAUD_FRCTN_EN
    return (n % 16) / 2;
`else
    return 0;
`endif
  endfunction

  task automatic push_exp(input bit is_err, input int b, input int f, input bit l);
    exp_t e;
    e.is_err = is_err; e.baud = b; e.frac = f; e.lck = l;
    q.push_back(e);
  endtask

  task automatic expect_frame(input int lo, input int hi);
    if (meas_pass(lo, hi)) begin
      hold_baud   = model_baud(lo);
      hold_frac   = model_frac(lo);
      hold_locked = 1'b1;
      push_exp(1'b0, hold_baud, hold_frac, 1'b1);
    end else begin
      push_exp(1'b1, 0, 0, hold_locked);
    end
  endtask

  // Monitor: every upd/err pulse must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && (baud_upd || err)) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event upd=%0d err=%0d baud=%0d required=no_event",
                   baud_upd, err, baud_val);
        end else begin
          e = q.pop_front();
          chk("event_err", int'(err), int'(e.is_err));
          chk("event_upd", int'(baud_upd), int'(!e.is_err));
          if (!e.is_err) begin
            chk("event_baud", int'(baud_val), e.baud);
            chk("event_frac", int'(baud_val_fraction), e.frac);
          end
          chk("event_locked", int'(locked), int'(e.lck));
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    cyc(1);
    restart = 1'b0;
    hold_locked = 1'b0;
    cyc(10);
  endtask

  task automatic frame(input int lo, input int hi, input int tail);
    rx = 1'b0; cyc(lo);
    rx = 1'b1; cyc(hi);
    rx = 1'b0; cyc(tail);
    rx = 1'b1; cyc(12);
  endtask

  task automatic sync55(input int n);
    for (int i = 0; i < 10; i++) begin
      rx = i[0];
      cyc(n);
    end
    rx = 1'b1;
    cyc(12);
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (q.size() != 0 && t < 300) begin
      cyc(1);
      t++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending=%0d required=0", tag, q.size());
      q.delete();
    end
  endtask

  task automatic check_hold(input string tag);
    chk({tag, "_baud"}, int'(baud_val), hold_baud);
    chk({tag, "_frac"}, int'(baud_val_fraction), hold_frac);
    chk({tag, "_locked"}, int'(locked), int'(hold_locked));
  endtask

  initial begin
    int lo, hi, tol, kind;
    reset_n = 1'b0; autobaud_en = 1'b1; restart = 1'b0; rx = 1'b1;
    cfg_load = 1'b0; cfg_baud_val = '0; cfg_fraction = '0;
    cyc(3);
    chk("rst_baud", int'(baud_val), 0);
    chk("rst_frac", int'(baud_val_fraction), 0);
    chk("rst_upd", int'(baud_upd), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err", int'(err), 0);
    reset_n = 1'b1;
    cyc(10);

    expect_frame(434, 434);
    sync55(434);
    drain("n434");
    check_hold("n434");
    chk("n434_const_baud", int'(baud_val), 26);
`ifdef UART_AUTOBAUD_FRCTN_EN
    chk("n434_const_frac", int'(baud_val_fraction), 1);
`else
    chk("n434_const_frac", int'(baud_val_fraction), 0);
`endif

    do_restart();
    expect_frame(440, 440);
    sync55(440);
    drain("n440");
    check_hold("n440");
`ifdef UART_AUTOBAUD_FRCTN_EN
    chk("n440_const_baud", int'(baud_val), 26);
`else
    chk("n440_const_baud", int'(baud_val), 27);
`endif

    do_restart();
    expect_frame(20, 20);
    frame(20, 20, 20);
    drain("glitch");
    check_hold("glitch");
    expect_frame(434, 434);
    sync55(434);
    drain("relock");
    check_hold("relock");

    do_restart();
    expect_frame(434, 520);
    frame(434, 520, 434);
    drain("mismatch");
    check_hold("mismatch");

    do_restart();
    push_exp(1'b1, 0, 0, 1'b0);
    rx = 1'b0;
    cyc((1 << CNT_W) + 100);
    rx = 1'b1;
    cyc(10);
    drain("timeout");
    check_hold("timeout");

    do_restart();
    rx = 1'b0; cyc(100);
    autobaud_en = 1'b0; cyc(3);
    autobaud_en = 1'b1; rx = 1'b1; cyc(20);
    check_hold("disable");

    for (int i = 0; i < 16; i++) begin
      do_restart();
      kind = int'($urandom_range(0, 4));
      lo = int'($urandom_range(32, 900));
      tol = lo / 8;
      case (kind)
        0: hi = lo - tol + int'($urandom_range(0, 2 * tol));
        1: begin lo = int'($urandom_range(4, 31)); hi = lo + int'($urandom_range(0, 3)); end
        2: hi = $urandom_range(0, 1) ? lo + tol + 1 + int'($urandom_range(0, 40))
                                     : lo - tol - 1 - int'($urandom_range(0, 20));
        3: hi = $urandom_range(0, 1) ? lo + tol : lo - tol;
        default: begin lo = MIN_CNT - 1 + int'($urandom_range(0, 1)); hi = lo; end
      endcase
      expect_frame(lo, hi);
      frame(lo, hi, 10);
      drain("rand");
      check_hold("rand");
    end

    do_restart();
    rx = 1'b0; cyc(50);
    cfg_baud_val = 13'd100; cfg_fraction = 3'd5;
    cfg_load = 1'b1; restart = 1'b1;
    hold_baud = 100;
`ifdef UART_AUTOBAUD_FRCTN_EN
    hold_frac = 5;
`else
    hold_frac = 0;
`endif
    hold_locked = 1'b1;
    push_exp(1'b0, hold_baud, hold_frac, 1'b1);
    cyc(1);
    cfg_load = 1'b0; restart = 1'b0;
    cyc(5);
    rx = 1'b1; cyc(40);
    frame(40, 40, 40);
    drain("cfg_load");
    check_hold("cfg_load");

    do_restart();
    rx = 1'b0; cyc(434);
    rx = 1'b1; cyc(100);
    reset_n = 1'b0;
    #1;
    hold_baud = 0; hold_frac = 0; hold_locked = 1'b0;
    check_hold("midhi_rst");
    chk("midhi_rst_upd", int'(baud_upd), 0);
    chk("midhi_rst_err", int'(err), 0);
    cyc(3);
    reset_n = 1'b1;
    cyc(10);
    expect_frame(434, 434);
    sync55(434);
    drain("after_rst");
    check_hold("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
